// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope plus a two-stage gain pipeline; the envelope advances once per sample tick.
// States: IDLE=0 silent, env 0 | ATTACK=1 rising to max | DECAY=2 falling to sustain | SUSTAIN=3 follows sustain level | RELEASE=4 falling to 0

module adsr_envelope #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ENV_WIDTH    = 16,
    parameter int RATE_WIDTH   = 16
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           tick_in,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                           gate_in,
    input  logic                           retrig_in,
    input  logic        [RATE_WIDTH-1:0]   attack_rate_in,
    input  logic        [RATE_WIDTH-1:0]   decay_rate_in,
    input  logic        [ENV_WIDTH-1:0]    sustain_level_in,
    input  logic        [RATE_WIDTH-1:0]   release_rate_in,
    output logic signed [SAMPLE_WIDTH-1:0] sample_out,
    output logic                           valid_out,
    output logic        [ENV_WIDTH-1:0]    env_out,
    output logic        [2:0]              state_out,
    output logic                           active_out
);

    localparam int SUMW  = RATE_WIDTH + ENV_WIDTH + 1;
    localparam int PRODW = SAMPLE_WIDTH + ENV_WIDTH + 1;
    localparam logic [ENV_WIDTH-1:0] ENV_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    state_t                w_entry;
    logic [ENV_WIDTH-1:0]  r_env;
    logic [ENV_WIDTH-1:0]  w_env_nxt;
    logic                  r_active;
    logic                  r_retrig;
    logic                  w_retrig_eff;
    logic [SUMW-1:0]       w_env_ext;
    logic [SUMW-1:0]       w_att_sum;
    logic [SUMW-1:0]       w_dec_floor;
    logic [SUMW-1:0]       w_rel_ext;

    logic signed [SAMPLE_WIDTH-1:0] r_sample;
    logic signed [PRODW-1:0]        r_prod;
    logic signed [SAMPLE_WIDTH-1:0] r_sample_out;
    logic                           r_v1;
    logic                           r_v2;
    logic                           r_valid_out;

    // Wide arithmetic so attack cannot wrap and decay/release cannot underflow.
    assign w_env_ext    = SUMW'(r_env);
    assign w_att_sum    = w_env_ext + SUMW'(attack_rate_in);
    assign w_dec_floor  = SUMW'(decay_rate_in) + SUMW'(sustain_level_in);
    assign w_rel_ext    = SUMW'(release_rate_in);
    assign w_retrig_eff = r_retrig | retrig_in;

    always_comb begin
        w_entry     = r_state;
        w_state_nxt = r_state;
        w_env_nxt   = r_env;
        if (tick_in) begin
            case (r_state)
                ST_ATTACK, ST_DECAY, ST_SUSTAIN: begin
                    if (!gate_in) begin
                        w_entry = ST_RELEASE;
                    end else if (w_retrig_eff) begin
                        w_entry = ST_ATTACK;
                    end
                end
                ST_IDLE, ST_RELEASE: begin
                    if (gate_in) begin
                        w_entry = ST_ATTACK;
                    end
                end
                default: w_entry = ST_IDLE;
            endcase

            // The level update of the state being entered applies on this same tick.
            w_state_nxt = w_entry;
            case (w_entry)
                ST_ATTACK: begin
                    if (attack_rate_in == '0 || w_att_sum >= SUMW'(ENV_MAX)) begin
                        w_env_nxt   = ENV_MAX;
                        w_state_nxt = ST_DECAY;
                    end else begin
                        w_env_nxt = w_att_sum[ENV_WIDTH-1:0];
                    end
                end
                ST_DECAY: begin
                    if (decay_rate_in == '0 || w_dec_floor >= w_env_ext) begin
                        w_env_nxt   = sustain_level_in;
                        w_state_nxt = ST_SUSTAIN;
                    end else begin
                        w_env_nxt = r_env - ENV_WIDTH'(decay_rate_in);
                    end
                end
                ST_SUSTAIN: begin
                    w_env_nxt = sustain_level_in;
                end
                ST_RELEASE: begin
                    if (release_rate_in == '0 || w_rel_ext >= w_env_ext) begin
                        w_env_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_env_nxt = r_env - ENV_WIDTH'(release_rate_in);
                    end
                end
                default: begin
                    w_env_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state  <= ST_IDLE;
            r_env    <= '0;
            r_active <= 1'b0;
            r_retrig <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_env    <= w_env_nxt;
            r_active <= (w_state_nxt != ST_IDLE);
            r_retrig <= tick_in ? 1'b0 : w_retrig_eff;
        end
    end

    // Gain: capture at tick, multiply one cycle later, scale and present the next.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_sample     <= '0;
            r_prod       <= '0;
            r_sample_out <= '0;
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_valid_out  <= 1'b0;
        end else begin
            r_v1        <= tick_in;
            r_v2        <= r_v1;
            r_valid_out <= r_v2;
            if (tick_in) begin
                r_sample <= sample_in;
            end
            if (r_v1) begin
                r_prod <= PRODW'(r_sample) * PRODW'($signed({1'b0, r_env}));
            end
            if (r_v2) begin
                r_sample_out <= SAMPLE_WIDTH'(r_prod >>> ENV_WIDTH);
            end
        end
    end

    assign sample_out = r_sample_out;
    assign valid_out  = r_valid_out;
    assign env_out    = r_env;
    assign state_out  = r_state;
    assign active_out = r_active;

endmodule
